// File: rtl/rca_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk slices in one operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled register with synchronous active-high reset to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold q unless enabled; reset wins over the enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full adders.
module rca_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: accepts operands, adds CHUNK bits per clock
// through a registered carry, then presents sum/cout/ovf until consumed.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_t           state;
  state_t           state_d;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] sum_d;
  logic [1:0]       flags_d;
  logic [1:0]       flags;

  // Handshakes come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign accept    = in_ready && in_valid;
  assign step      = (state == ADD);
  assign last_step = step && (idx == LAST_IDX);

  // One shared slice adder, steered by the chunk index.
  assign chunk_a = op_a[idx*CHUNK +: CHUNK];
  assign chunk_b = op_b[idx*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry),
    .s  (chunk_s),
    .co (chunk_c)
  );

  // Next-state decode for IDLE -> ADD -> DONE -> IDLE.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid)  state_d = ADD;
      ADD:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result datapath: clear on accept, splice in one slice per ADD cycle.
  always_comb begin
    sum_d   = sum;
    flags_d = flags;
    if (accept) begin
      sum_d   = '0;
      flags_d = 2'b00;
    end else if (step) begin
      sum_d[idx*CHUNK +: CHUNK] = chunk_s;
      // Signed overflow: like-signed operands producing an opposite-signed MSB.
      flags_d = {chunk_c,
                 (op_a[WIDTH-1] == op_b[WIDTH-1]) && (chunk_s[CHUNK-1] != op_a[WIDTH-1])};
    end
  end

  // FSM state, slice index and inter-slice carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        idx   <= '0;
        carry <= cin;
      end else if (step) begin
        idx   <= idx + 1'b1;
        carry <= chunk_c;
      end
    end
  end

  dff #(.W(WIDTH)) u_op_a (
    .clk (clk), .rst (rst), .en (accept), .d (a), .q (op_a)
  );

  dff #(.W(WIDTH)) u_op_b (
    .clk (clk), .rst (rst), .en (accept), .d (b), .q (op_b)
  );

  dff #(.W(WIDTH)) u_sum (
    .clk (clk), .rst (rst), .en (accept || step), .d (sum_d), .q (sum)
  );

  // cout/ovf only change on accept (clear) or on the final slice.
  dff #(.W(2)) u_flags (
    .clk (clk), .rst (rst), .en (accept || last_step), .d (flags_d), .q (flags)
  );

  assign cout = flags[1];
  assign ovf  = flags[0];

endmodule
